// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX message arbiter and its producers.
package uart_arb_pkg;

    // Default requester count and fixed requester slots
    localparam int unsigned N_REQ_DEFAULT = 4;
    localparam int unsigned REQ_DHT11     = 0;
    localparam int unsigned REQ_SR04      = 1;
    localparam int unsigned REQ_KEY       = 2;
    localparam int unsigned REQ_TIME      = 3;

    // Line terminators producers use for their final byte
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first valid requester scanning upward from rr_ptr_i with wrap.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IdxW-1:0]  rr_ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             any_valid_o
);

    logic [2*N_REQ-1:0] dbl_valid;
    logic [2*N_REQ-1:0] dbl_pick;
    logic [N_REQ-1:0]   rot_valid;
    logic [N_REQ-1:0]   rot_pick;

    // Rotate so rr_ptr_i sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        dbl_valid   = {req_valid_i, req_valid_i} >> rr_ptr_i;
        rot_valid   = dbl_valid[N_REQ-1:0];
        rot_pick    = rot_valid & (~rot_valid + N_REQ'(1));
        dbl_pick    = {rot_pick, rot_pick} << rr_ptr_i;
        pick_o      = dbl_pick[2*N_REQ-1:N_REQ];
        any_valid_o = |req_valid_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of the UART TX FIFO push port.
// A grant is held for a whole message (until a byte with last=1 is pushed).
// Optional owner-idle abort is built when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEFAULT,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic               fifo_full_i,
    output logic               fifo_push_o,
    output logic [7:0]         fifo_wdata_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_abort_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IdxW-1:0]  owner_q;
    logic [IdxW-1:0]  rr_ptr_q;

    logic [N_REQ-1:0] pick;
    logic             any_valid;
    logic [IdxW-1:0]  pick_idx;
    logic [IdxW-1:0]  next_ptr;
    logic [7:0]       data_arr [N_REQ];
    logic             owner_valid;
    logic             owner_last;
    logic             transfer;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0] idle_cnt_q;
    logic            timeout_abort_q;
    assign timeout_abort_o = timeout_abort_q;
`else
    logic unused_timeout;
    assign unused_timeout  = ^TIMEOUT;
    assign timeout_abort_o = 1'b0;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_rr_picker (
        .req_valid_i (req_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .pick_o      (pick),
        .any_valid_o (any_valid)
    );

    // Encode one-hot pick, slice per-requester bytes, compute the post-message pointer
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data_i[8*i +: 8];
            if (pick[i]) begin
                pick_idx = IdxW'(i);
            end
        end
        next_ptr    = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        owner_valid = req_valid_i[owner_q];
        owner_last  = req_last_i[owner_q];
        transfer    = (state_q == StBusy) && owner_valid && !fifo_full_i;
    end

    // Owner-side handshake and FIFO write port; FIFO full gates ready in the same cycle
    always_comb begin
        req_ready_o  = '0;
        fifo_push_o  = 1'b0;
        fifo_wdata_o = '0;
        if (state_q == StBusy) begin
            req_ready_o[owner_q] = !fifo_full_i;
            if (transfer) begin
                fifo_push_o  = 1'b1;
                fifo_wdata_o = data_arr[owner_q];
            end
        end
    end

    // Arbitration FSM: grant in IDLE, hold until last byte (or idle abort)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            grant_q         <= '0;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q      <= '0;
            timeout_abort_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_abort_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        state_q    <= StBusy;
                        grant_q    <= pick;
                        owner_q    <= pick_idx;
`ifdef ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (transfer && owner_last) begin
                        state_q  <= StIdle;
                        grant_q  <= '0;
                        rr_ptr_q <= next_ptr;
                    end
`ifdef ARB_TIMEOUT_EN
                    // FIFO-full stalls keep owner_valid high, so they never count
                    else if (owner_valid) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q         <= StIdle;
                        grant_q         <= '0;
                        rr_ptr_q        <= next_ptr;
                        idle_cnt_q      <= '0;
                        timeout_abort_q <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == StBusy);

endmodule
